// File: rtl/div5_seq_ctrl_if.sv
// rtl/div5_seq_ctrl_if.sv - handshake bundle for div5_seq_ctrl; remainder present with DIV5_SEQ_REMAINDER_EN
interface div5_seq_ctrl_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
`ifdef DIV5_SEQ_REMAINDER_EN
  logic [2:0]   remainder;
`endif
  logic         busy;

  // Divider side
  modport slave (
    input  in_valid, dividend, out_ready,
`ifdef DIV5_SEQ_REMAINDER_EN
    output remainder,
`endif
    output in_ready, out_valid, quotient, busy
  );

  // Producer/consumer side
  modport master (
    output in_valid, dividend, out_ready,
`ifdef DIV5_SEQ_REMAINDER_EN
    input  remainder,
`endif
    input  in_ready, out_valid, quotient, busy
  );
endinterface

// File: rtl/div5_seq_ctrl.sv
// rtl/div5_seq_ctrl.sv - sequential divide-by-5, 3 bits per step over 22 steps; remainder port via DIV5_SEQ_REMAINDER_EN
module div5_seq_ctrl #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  div5_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;

  // Dividend shift register carries two leading zeros so 66 bits split into 22 whole 3-bit chunks.
  logic [W+1:0] sh_q;
  // The full quotient is 66 bits but its top 2 bits are always zero, so only the low W are kept.
  logic [W-1:0] quo_q;
  logic [2:0]   r_q;
  logic [4:0]   cnt_q;

  logic [2:0]   chunk;
  logic [2:0]   step_q;
  logic [2:0]   step_r;

  // One radix-8 digit of division by 5: v = 8*r + d (0..39 for r <= 4) via compare ladder.
  function automatic logic [5:0] div5_step(input logic [2:0] r, input logic [2:0] d);
    logic [5:0] v;
    logic [2:0] q;
    logic [2:0] rem;
    v = {r, d};
    if (v >= 6'd35) begin
      q = 3'd7; rem = 3'(v - 6'd35);
    end else if (v >= 6'd30) begin
      q = 3'd6; rem = 3'(v - 6'd30);
    end else if (v >= 6'd25) begin
      q = 3'd5; rem = 3'(v - 6'd25);
    end else if (v >= 6'd20) begin
      q = 3'd4; rem = 3'(v - 6'd20);
    end else if (v >= 6'd15) begin
      q = 3'd3; rem = 3'(v - 6'd15);
    end else if (v >= 6'd10) begin
      q = 3'd2; rem = 3'(v - 6'd10);
    end else if (v >= 6'd5) begin
      q = 3'd1; rem = 3'(v - 6'd5);
    end else begin
      q = 3'd0; rem = v[2:0];
    end
    return {q, rem};
  endfunction

  // Current digit step on the top chunk of the shift register
  always_comb begin
    chunk            = sh_q[W+1:W-1];
    {step_q, step_r} = div5_step(r_q, chunk);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (cnt_q == 5'd0) state_d = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, one digit per RUN edge, hold in DONE and IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      quo_q <= '0;
      r_q   <= 3'd0;
      cnt_q <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sh_q  <= {2'b00, bus.dividend};
            quo_q <= '0;
            r_q   <= 3'd0;
            cnt_q <= 5'd21;
          end
        end
        RUN: begin
          sh_q  <= {sh_q[W-2:0], 3'b000};
          quo_q <= {quo_q[W-4:0], step_q};
          r_q   <= step_r;
          if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.quotient = quo_q;

`ifdef DIV5_SEQ_REMAINDER_EN
  assign bus.remainder = r_q;
`endif

endmodule
